muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers.
- Sits downstream of the multicycle control FSM, beside the ALU in the datapath.
- The controller issues one operation with a single-cycle `start` and holds in its EXE state while `busy` is high.
- HI/LO feed the register write-data mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  issue pulse; sampled only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved (no-op, done still pulses).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid for the op in that same cycle.
- dz  out  1  sticky divide-by-zero flag for the last DIV/DIVU; cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, dz=0, hi=0, lo=0; counter=0. Reset mid-operation aborts the op and leaves HI/LO at 0.
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch a, b and op; go to PREP.
  - start=1 with MTHI/MTLO: write hi (or lo) = a at that edge; stay IDLE; done=1 next cycle; busy stays 0.
- PREP (1 cycle):
  - Signed ops: take |a| and |b|; record result sign (quotient sign = a^b, remainder sign = sign of a; product sign = a^b).
  - Clear the accumulator; counter=0.
  - DIV/DIVU with b==0: set dz.
- CALC (exactly WIDTH cycles; counter 0..WIDTH-1):
  - Multiply: radix-2 shift-add over a 2*WIDTH product register.
  - Divide: restoring division, one quotient bit per cycle.
  - When counter=WIDTH-1, go to FIX.
- FIX (1 cycle): apply two's-complement sign correction; on the exit edge write hi/lo and return to IDLE; done=1 for the following cycle.
- Result placement:
  - MULT/MULTU: {hi,lo} = product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Latency: start accepted at edge E0; busy=1 from E0 through E0+WIDTH+2; done=1 in the cycle after edge E0+WIDTH+2 (34 cycles for WIDTH=32). A new start is accepted in that same done cycle.
- start while busy: ignored; no queueing. Operands are latched at E0, so a/b may change afterwards.
- Divide by zero: lo = all ones, hi = a (unsigned magnitude path, then sign fix skipped); dz=1.
- Signed overflow (DIV of 0x80000000 by -1): lo=0x80000000, hi=0; no flag.
- Remainder sign always follows the dividend (truncating division).
- hi/lo are unchanged except at a FIX exit or an MTHI/MTLO write.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: in PREP, if MULT/MULTU has a==0 or b==0, or DIV/DIVU has b==0, skip CALC and go to FIX. Results are identical to the full path; done arrives 2 cycles after start (done in the cycle after E0+2).
- Undefined: every iterative op takes the full WIDTH+2 cycles regardless of operands.

Decomposition:
- Shared package holds:
  - op encodings (MD_MULT … MD_MTLO);
  - FSM state encodings (MDS_IDLE, MDS_PREP, MDS_CALC, MDS_FIX);
  - the controller-side "EXE hold while busy" contract constant.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (shift-add or restore-subtract selected by an is_div input).

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy high for 34 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2, dz=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, dz=1.
  - With MULDIV_ZERO_SKIP_EN: done 2 cycles after start.
  - Without it: done 34 cycles after start.
- Second start pulse (different operands) during busy -> ignored; result matches the first op. MTHI a=0xABCD in IDLE -> hi=0xABCD next cycle, busy never asserted.
- rst_n pulsed low at CALC counter=10 -> busy=0, done=0, hi=lo=0 immediately. A following MULTU 3×5 -> lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit (HI/LO registers).
// Holds op encodings, FSM state encodings and the controller hand-off contract.
// Optional zero-operand shortcut is built with `define MULDIV_ZERO_SKIP_EN.
package muldiv_pkg;

  // Operation codes presented on the op port by the controller.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_PREP = 2'd1,
    MDS_CALC = 2'd2,
    MDS_FIX  = 2'd3
  } md_state_e;

  // The controller stays in EXE for as long as busy is high; results are
  // only guaranteed in the single done cycle that follows.
  localparam bit MD_EXE_HOLD_WHILE_BUSY = 1'b1;

  // Ops that run through PREP/CALC/FIX.
  function automatic logic md_is_iter(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops whose operands are two's-complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Ops using the restoring-divide step.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add or restore-subtract.
// Purely combinational, zero latency.
// No flow control; the sequencer decides when the result is captured.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Select the shift-add or restoring-subtract update for one bit.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    partial = acc_i[2*WIDTH-1:WIDTH-1];
    // Remainder is always < divisor, so only the low WIDTH bits survive a subtract.
    diff    = partial[WIDTH-1:0] - opnd_i;
    fits    = (partial >= {1'b0, opnd_i});
    acc_o   = {sum, acc_i[WIDTH-1:1]};
    if (is_div) begin
      if (fits) begin
        acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {partial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// Latency WIDTH+2 cycles start-to-done (2 with MULDIV_ZERO_SKIP_EN on zero operands).
// No queueing: start is only sampled in IDLE; busy holds the controller in EXE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;       // raw dividend / multiplier as issued
  logic [WIDTH-1:0]   b_q, b_d;       // raw at issue, magnitude after PREP
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;   // product / quotient sign
  logic               rneg_q, rneg_d; // remainder sign (follows dividend)
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div;
  logic               is_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div = md_is_div(op_q);
  assign is_sgn = md_is_signed(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_i  (acc_q),
    .opnd_i (b_q),
    .acc_o  (step_acc)
  );

  // Operand magnitudes and final two's-complement corrections.
  always_comb begin
    a_mag    = (is_sgn && a_q[WIDTH-1]) ? (~a_q + ONE_W) : a_q;
    b_mag    = (is_sgn && b_q[WIDTH-1]) ? (~b_q + ONE_W) : b_q;
    prod_fix = neg_q ? (~acc_q + ONE_2W) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDS_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          if (md_is_iter(op)) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            busy_d  = 1'b1;
            state_d = MDS_PREP;
          end else begin
            // MTHI/MTLO and reserved codes complete immediately.
            done_d = 1'b1;
            if (op == MD_MTHI) hi_d = a;
            if (op == MD_MTLO) lo_d = a;
          end
        end
      end
      MDS_PREP: begin
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        b_d     = b_mag;
        neg_d   = is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = is_sgn && a_q[WIDTH-1];
        cnt_d   = '0;
        state_d = MDS_CALC;
        if (is_div && (b_q == '0)) dz_d = 1'b1;
`ifdef MULDIV_ZERO_SKIP_EN
        // Zero operands give a fixed result, so the iterations are skipped.
        if (is_div ? (b_q == '0) : ((a_q == '0) || (b_q == '0))) begin
          acc_d   = is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
          state_d = MDS_FIX;
        end
`endif
      end
      MDS_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = MDS_FIX;
        end
      end
      MDS_FIX: begin
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          // Divide by zero reports the original dividend, no sign fix.
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = MDS_IDLE;
      end
      default: state_d = MDS_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
